eth_header_streamer: RTL and testbench

ETH_HEADER_STREAMER -- requirements
Module: eth_header_streamer

---
 rtl/eth_hdr_pkg.sv | 19 +
 rtl/eth_hdr_prefetch_fifo.sv | 57 +++++
 rtl/eth_header_streamer.sv | 181 ++++++++++++++++++
 tb/tb_eth_header_streamer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_hdr_pkg.sv
// Shared definitions for the Ethernet header streamer.
// Contents: bus/length widths, default header geometry and the frame FSM state type.
package eth_hdr_pkg;

    localparam int unsigned DATA_W = 8;   // byte-wide data paths
    localparam int unsigned ADDR_W = 8;   // header RAM address width
    localparam int unsigned LEN_W  = 16;  // payload length / down-counter width
    localparam int unsigned IDX_W  = 9;   // header byte index, must hold 0..256

    localparam int unsigned HDR_LEN_DEFAULT  = 42;
    localparam int unsigned HDR_BASE_DEFAULT = 0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHdr  = 2'd1,
        StPay  = 2'd2
    } state_e;

endpackage

// File: rtl/eth_hdr_prefetch_fifo.sv
// Two-entry byte FIFO holding header RAM read data until the source accepts it.
// Ports:
//   clk_i, reset_i  clock and asynchronous active-high reset (empties the FIFO)
//   push_i          write push_data_i this cycle
//   pop_i           discard the head entry this cycle
//   head_o          oldest entry (meaningful only when count_o != 0)
//   count_o         current occupancy 0..2
// Writes into a full FIFO without a simultaneous pop and pops of an empty FIFO are dropped.
module eth_hdr_prefetch_fifo
    import eth_hdr_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    always_comb begin
        pop_ok  = pop_i && (count_q != 2'd0);
        push_ok = push_i && ((count_q != 2'd2) || pop_ok);
        count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/eth_header_streamer.sv
// Emits one Ethernet frame per start request: HDR_LEN header bytes fetched from a
// synchronous header RAM, followed by payload_len bytes passed through from a payload stream.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   start, payload_len             frame request and payload byte count (sampled on accept)
//   busy, done                     frame in progress / one-cycle completion pulse
//   hdr_address, hdr_chipselect,   header RAM read port, data returned one cycle later
//   hdr_readdata
//   pl_data, pl_valid, pl_ready    payload Avalon-ST sink
//   src_data, src_valid, src_ready Avalon-ST frame source with sop/eop
//   src_sop, src_eop
module eth_header_streamer
    import eth_hdr_pkg::*;
#(
    parameter int unsigned HDR_LEN  = HDR_LEN_DEFAULT,
    parameter int unsigned HDR_BASE = HDR_BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  payload_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] hdr_address,
    output logic              hdr_chipselect,
    input  logic [DATA_W-1:0] hdr_readdata,
    input  logic [DATA_W-1:0] pl_data,
    input  logic              pl_valid,
    output logic              pl_ready,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_sop,
    output logic              src_eop
);

    localparam logic [IDX_W-1:0]  HdrLenW = IDX_W'(HDR_LEN);
    localparam logic [IDX_W-1:0]  LastIdx = IDX_W'(HDR_LEN - 1);
    localparam logic [ADDR_W-1:0] BaseW   = ADDR_W'(HDR_BASE);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;    // header reads issued this frame
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;  // header bytes handed to the source
    logic [LEN_W-1:0]   pay_cnt_q, pay_cnt_d;  // payload bytes still to forward
    logic               pay_zero_q, pay_zero_d;
    logic               done_q, done_d;
    logic               inflight_q;            // a RAM read returns data this cycle
    logic [ADDR_W-1:0]  addr_q;

    logic [DATA_W-1:0]  fifo_head;
    logic [1:0]         fifo_count;
    logic               hdr_valid;
    logic               hdr_hs;
    logic               pay_hs;
    logic [2:0]         occ;
    logic               issue;

    eth_hdr_prefetch_fifo u_fifo (
        .clk_i       (clk),
        .reset_i     (reset),
        .push_i      (inflight_q),
        .push_data_i (hdr_readdata),
        .pop_i       (hdr_hs),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    // Occupancy is taken net of this cycle's pop so that a steady one-byte-per-cycle
    // stream keeps one entry buffered and one read in flight.
    always_comb begin
        hdr_valid = (state_q == StHdr) && (fifo_count != 2'd0);
        hdr_hs    = hdr_valid && src_ready;
        pay_hs    = (state_q == StPay) && pl_valid && src_ready;
        occ       = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, hdr_hs};
        issue     = (state_q == StHdr) && (rd_idx_q != HdrLenW) && (occ < 3'd2);
    end

    always_comb begin
        hdr_chipselect = issue;
        hdr_address    = issue ? (BaseW + rd_idx_q[ADDR_W-1:0]) : addr_q;
        busy           = (state_q != StIdle);
        done           = done_q;
    end

    always_comb begin
        src_valid = 1'b0;
        src_data  = '0;
        src_sop   = 1'b0;
        src_eop   = 1'b0;
        pl_ready  = 1'b0;
        unique case (state_q)
            StHdr: begin
                src_valid = hdr_valid;
                src_data  = fifo_head;
                src_sop   = hdr_valid && (out_idx_q == '0);
                src_eop   = hdr_valid && (out_idx_q == LastIdx) && pay_zero_q;
            end
            StPay: begin
                src_valid = pl_valid;
                src_data  = pl_data;
                pl_ready  = src_ready;
                src_eop   = pl_valid && (pay_cnt_q == LEN_W'(1));
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rd_idx_d   = rd_idx_q;
        out_idx_d  = out_idx_q;
        pay_cnt_d  = pay_cnt_q;
        pay_zero_d = pay_zero_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StHdr;
                    rd_idx_d   = '0;
                    out_idx_d  = '0;
                    pay_cnt_d  = payload_len;
                    pay_zero_d = (payload_len == '0);
                end
            end
            StHdr: begin
                if (issue) begin
                    rd_idx_d = rd_idx_q + IDX_W'(1);
                end
                if (hdr_hs) begin
                    out_idx_d = out_idx_q + IDX_W'(1);
                    if (out_idx_q == LastIdx) begin
                        if (pay_zero_q) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StPay;
                        end
                    end
                end
            end
            StPay: begin
                if (pay_hs && (pay_cnt_q != '0)) begin
                    pay_cnt_d = pay_cnt_q - LEN_W'(1);
                    if (pay_cnt_q == LEN_W'(1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            rd_idx_q   <= '0;
            out_idx_q  <= '0;
            pay_cnt_q  <= '0;
            pay_zero_q <= 1'b0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            addr_q     <= BaseW;
        end else begin
            state_q    <= state_d;
            rd_idx_q   <= rd_idx_d;
            out_idx_q  <= out_idx_d;
            pay_cnt_q  <= pay_cnt_d;
            pay_zero_q <= pay_zero_d;
            done_q     <= done_d;
            inflight_q <= issue;
            if (issue) begin
                addr_q <= hdr_address;
            end
        end
    end

endmodule

// File: tb/tb_eth_header_streamer.sv
module tb_eth_header_streamer;

    localparam int HL = 42;
    localparam int HB = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [15:0] payload_len;
    logic       busy, done;
    logic [7:0] hdr_address;
    logic       hdr_chipselect;
    logic [7:0] hdr_readdata;
    logic [7:0] pl_data;
    logic       pl_valid, pl_ready;
    logic [7:0] src_data;
    logic       src_valid, src_ready, src_sop, src_eop;

    always #5 clk = ~clk;

    eth_header_streamer #(
        .HDR_LEN  (HL),
        .HDR_BASE (HB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .payload_len    (payload_len),
        .busy           (busy),
        .done           (done),
        .hdr_address    (hdr_address),
        .hdr_chipselect (hdr_chipselect),
        .hdr_readdata   (hdr_readdata),
        .pl_data        (pl_data),
        .pl_valid       (pl_valid),
        .pl_ready       (pl_ready),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .src_sop        (src_sop),
        .src_eop        (src_eop)
    );

    // Synchronous header RAM: data one cycle after the chipselect cycle.
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (hdr_chipselect) hdr_readdata <= ram[hdr_address];
    end

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } cap_t;

    typedef struct {
        int plen;
        bit rmode;     // random src_ready
        bit gmode;     // random pl_valid gaps
        bit dup;       // extra start while busy
        int exp_len;
        bit exp_plr;   // pl_ready expected to be seen
        int exp_span;  // cycles between sop and eop handshakes, -1 = not checked
    } vec_t;

    // Monitor state (written only by the monitor process)
    cap_t cap[$];
    int   rd_cnt [256];
    int   reads, hdr_hs, max_out, stab_viol, done_cnt, done_viol, cyc;
    int   start_cyc, first_cs_cyc, first_v_cyc, sop_cyc, eop_cyc;
    bit   plr_seen, prev_stall, eop_prev, pl_hs_q;
    logic [7:0] pd;
    logic ps, pe;
    bit   mon_clr = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_clr) begin
                cap.delete();
                for (int a = 0; a < 256; a++) rd_cnt[a] = 0;
                reads = 0; hdr_hs = 0; max_out = 0; stab_viol = 0; done_cnt = 0;
                done_viol = 0; cyc = 0; start_cyc = -1; first_cs_cyc = -1;
                first_v_cyc = -1; sop_cyc = -1; eop_cyc = -1;
                plr_seen = 0; prev_stall = 0; eop_prev = 0;
            end else if (!reset) begin
                cyc++;
                if (start && !busy && start_cyc < 0) start_cyc = cyc;
                if (hdr_chipselect) begin
                    rd_cnt[hdr_address]++;
                    reads++;
                    if (first_cs_cyc < 0) first_cs_cyc = cyc;
                end
                if (src_valid && first_v_cyc < 0) first_v_cyc = cyc;
                if (pl_ready) plr_seen = 1;
                if (prev_stall && (!src_valid || src_data != pd || src_sop != ps || src_eop != pe))
                    stab_viol++;
                if (done != eop_prev || (done && busy)) done_viol++;
                if (done) done_cnt++;
                if (src_valid && src_ready) begin
                    cap.push_back('{d: src_data, sop: src_sop, eop: src_eop});
                    if (!pl_ready) hdr_hs++;
                    if (src_sop && sop_cyc < 0) sop_cyc = cyc;
                    if (src_eop) eop_cyc = cyc;
                end
                if (reads - hdr_hs > max_out) max_out = reads - hdr_hs;
                eop_prev   = src_valid && src_ready && src_eop;
                prev_stall = src_valid && !src_ready;
                pd = src_data; ps = src_sop; pe = src_eop;
            end
            pl_hs_q = pl_valid && pl_ready;
        end
    end

    int errors = 0;
    int checks = 0;
    bit rmode, gmode;
    int plen_cur, pidx;
    logic [7:0] pay [64];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        src_ready = rmode ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (pl_hs_q) pidx++;
        if (!(pl_valid && !pl_hs_q)) begin
            pl_valid = (pidx < plen_cur) && (gmode ? ($urandom_range(0, 1) == 1) : 1'b1);
            pl_data  = pay[pidx % 64];
        end
    endtask

    task automatic check_rst_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_cs"}, int'(hdr_chipselect), 0);
        check({tag, "_addr"}, int'(hdr_address), HB);
        check({tag, "_pl_ready"}, int'(pl_ready), 0);
        check({tag, "_valid"}, int'(src_valid), 0);
        check({tag, "_sop"}, int'(src_sop), 0);
        check({tag, "_eop"}, int'(src_eop), 0);
        check({tag, "_data"}, int'(src_data), 0);
    endtask

    task automatic prep(input int plen, input bit rm, input bit gm);
        rmode = rm; gmode = gm;
        for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
        plen_cur = plen; pidx = 0; pl_valid = 1'b0; pl_data = 8'h00;
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        cap_t exp_q[$];
        int   k, mism, bad, n;
        prep(v.plen, v.rmode, v.gmode);
        payload_len = 16'(v.plen);
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (done_cnt == 0 && k < 3000) begin
            start = v.dup && (k == 6);
            step();
            k++;
        end
        start = 1'b0;
        check("timeout", int'(done_cnt == 0), 0);
        repeat (8) step();
        // Reference frame: header bytes from RAM in address order, then the payload.
        for (int i = 0; i < HL; i++)
            exp_q.push_back('{d: ram[HB + i], sop: (i == 0), eop: (i == HL - 1 && v.plen == 0)});
        for (int j = 0; j < v.plen; j++)
            exp_q.push_back('{d: pay[j], sop: 1'b0, eop: (j == v.plen - 1)});
        check("frame_len", cap.size(), v.exp_len);
        mism = 0;
        n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (cap[i] != exp_q[i]) mism++;
        check("byte_seq", mism, 0);
        bad = 0;
        for (int a = 0; a < 256; a++)
            if (rd_cnt[a] != (((a >= HB) && (a < HB + HL)) ? 1 : 0)) bad++;
        check("ram_reads", bad, 0);
        check("fifo_bound", int'(max_out > 2), 0);
        check("stall_hold", stab_viol, 0);
        check("done_cnt", done_cnt, 1);
        check("done_timing", done_viol, 0);
        check("pl_ready_seen", int'(plr_seen), int'(v.exp_plr));
        check("first_read", first_cs_cyc - start_cyc, 1);
        check("first_valid", int'((first_v_cyc - first_cs_cyc) <= 2), 1);
        if (v.exp_span >= 0) check("contiguous", eop_cyc - sop_cyc, v.exp_span);
    endtask

    vec_t vecs[$];

    initial begin
        int k, n_eop;
        for (int a = 0; a < 256; a++) ram[a] = 8'(a);
        reset = 1'b1; start = 1'b0; payload_len = 16'd0;
        src_ready = 1'b0; pl_valid = 1'b0; pl_data = 8'h00;
        rmode = 0; gmode = 0; plen_cur = 0; pidx = 0;
        repeat (2) @(posedge clk);
        #1;
        check_rst_outputs("init");
        reset = 1'b0;

        vecs.push_back('{plen: 4, rmode: 0, gmode: 0, dup: 0, exp_len: 46, exp_plr: 1, exp_span: 45});
        vecs.push_back('{plen: 0, rmode: 0, gmode: 0, dup: 0, exp_len: 42, exp_plr: 0, exp_span: 41});
        vecs.push_back('{plen: 4, rmode: 1, gmode: 0, dup: 0, exp_len: 46, exp_plr: 1, exp_span: -1});
        vecs.push_back('{plen: 3, rmode: 0, gmode: 1, dup: 0, exp_len: 45, exp_plr: 1, exp_span: -1});
        vecs.push_back('{plen: 3, rmode: 1, gmode: 1, dup: 0, exp_len: 45, exp_plr: 1, exp_span: -1});
        vecs.push_back('{plen: 1, rmode: 0, gmode: 0, dup: 1, exp_len: 43, exp_plr: 1, exp_span: 42});
        vecs.push_back('{plen: 9, rmode: 1, gmode: 1, dup: 1, exp_len: 51, exp_plr: 1, exp_span: -1});
        vecs.push_back('{plen: 0, rmode: 1, gmode: 0, dup: 0, exp_len: 42, exp_plr: 0, exp_span: -1});
        foreach (vecs[i]) run_frame(vecs[i]);

        // Reset while header byte 10 is on the bus.
        prep(4, 0, 0);
        payload_len = 16'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (hdr_hs < 10 && k < 500) begin
            step();
            k++;
        end
        check("rst_bytes_before", cap.size(), 10);
        n_eop = 0;
        foreach (cap[i]) if (cap[i].eop) n_eop++;
        check("rst_no_eop", n_eop, 0);
        reset = 1'b1;
        #1;
        check_rst_outputs("midrst");
        repeat (3) step();
        reset = 1'b0;
        run_frame('{plen: 4, rmode: 0, gmode: 0, dup: 0, exp_len: 46, exp_plr: 1, exp_span: 45});

        // Start accepted in the done cycle of the previous frame.
        prep(2, 0, 0);
        payload_len = 16'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (!eop_prev && k < 500) begin
            step();
            k++;
        end
        check("b2b_done_now", int'(done), 1);
        check("b2b_busy_low", int'(busy), 0);
        payload_len = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        check("b2b_busy", int'(busy), 1);
        check("b2b_cs", int'(hdr_chipselect), 1);
        check("b2b_addr", int'(hdr_address), HB);
        k = 0;
        while (done_cnt < 2 && k < 500) begin
            step();
            k++;
        end
        repeat (4) step();
        check("b2b_done_cnt", done_cnt, 2);
        check("b2b_len", cap.size(), 44 + 42);
        check("b2b_last_eop", int'(cap.size() > 0 && cap[cap.size() - 1].eop), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
